sad_s00_axi_slave: RTL
======================

# sad_s00_axi_slave

AXI4-Lite slave front end for the SAD accelerator. It terminates the S00_AXI port driven by the PS or the master VIP, and holds four 32-bit read/write registers at offsets 0x0–0xC. It also computes a byte-lane sum of absolute differences between registers 0 and 1 in a two-stage pipeline, which it exports to the datapath.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; selects 4 words.

Ports:
- S_AXI_ACLK  in  1  single clock for the whole block.
- S_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- sad_result  out  32  zero-extended 10-bit SAD of reg0 and reg1 byte lanes.
- sad_valid  out  1  one-cycle pulse when sad_result updates.

## Operation
- Register map: word index = ADDR[3:2]; ADDR[1:0] ignored. Index 0–3 map to slv_reg0–3. All four are plain read/write with no side effects on readback.
- Write channel:
  - Accept only when AWVALID && WVALID && !BVALID.
  - In that cycle, pulse AWREADY and WREADY high together for exactly one cycle.
  - Commit WDATA into the addressed register on that edge, byte-masked by WSTRB; bytes with WSTRB=0 are unchanged.
  - AW without W, or W without AW: stall with both READY signals low; nothing is latched.
- Write response: BVALID rises the cycle after the handshake and holds until BREADY is sampled high. No new write is accepted while BVALID=1.
- Read channel:
  - Accept when ARVALID && !RVALID.
  - Pulse ARREADY for one cycle.
  - RDATA is the addressed register value sampled at that edge.
  - RVALID rises the next cycle and holds, with RDATA stable, until RREADY.
- Read and write in the same cycle: both are accepted. If they target the same register, the read returns the pre-write value.
- SAD pipeline:
  - Stage 1 registers |reg0[8k+7:8k] − reg1[8k+7:8k]| for k=0..3, as unsigned 8-bit values.
  - Stage 2 registers their 10-bit sum into sad_result[9:0]; sad_result[31:10]=0.
  - Stage 1 is triggered by any committed write to index 0 or 1, including partial strobes.
  - sad_valid pulses 2 cycles after the write edge.
  - Back-to-back writes produce back-to-back pulses, each reflecting register contents after its own write.

## Timing
- Reset (ARESETN low, asynchronous assert): all registers, AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, sad_result and sad_valid go to 0 immediately. BRESP and RRESP are constant 0.
- Reset deassertion: synchronous release. The first handshake is possible on the first rising edge with ARESETN high.
- Reset mid-transaction: any pending BVALID/RVALID is dropped; no response is issued for it.
- Minimum write throughput: 1 write per 2 cycles with BREADY tied high. Read throughput is the same.
- Write latency: AW/W handshake at edge N; register updated at N; BVALID high after N.
- Read latency: ARREADY at edge N; RVALID/RDATA valid after N.
- SAD latency: write at edge N; sad_valid high for the cycle after edge N+2.

## Structure
- Shared package `sad_pkg`: register index constants (SAD_REG_A=0, SAD_REG_B=1, SAD_REG_2=2, SAD_REG_3=3), OKAY response constant, SAD width constant (10).
- One sub-module, `sad_byte_pipe`, holds the 2-stage abs-diff/sum pipeline with inputs a, b (32 bits each) and a trigger.
- The AXI handshake logic and register file stay in the top module.

## Test plan
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then reads of the same addresses → each returns its written value with BRESP/RRESP=0.
- Write 0xFFFFFFFF to 0x8, then write 0x000000AB with WSTRB=4'b0001 → read of 0x8 returns 0xFFFFFFAB.
- AWVALID asserted 3 cycles before WVALID, with BREADY held low 5 cycles → no READY until both valids are high; BVALID held 5 cycles; second write not accepted until BREADY.
- reg0=0x10203040 then reg1=0x40302010 → sad_valid pulses twice; the final sad_result=0x00000080. Write 0x0 with WSTRB=0 → sad_valid pulses, value unchanged.
- Simultaneous write of 0x55 and read to 0x4, which previously held 0x2 → RDATA=0x2; the next read returns 0x55.
- Drop ARESETN while RVALID=1 and RREADY=0 → all outputs 0 immediately; a subsequent read of any register returns 0.

Source files
------------

// File: rtl/sad_pkg.sv
// -----------------------------------------------------------------------------
// sad_pkg
// Shared constants and types for the SAD accelerator AXI4-Lite front end.
//   - register indices of the four slave registers
//   - AXI response code, SAD lane geometry and result width
//   - write/read channel state encodings
//   - abs_diff(): unsigned absolute difference of two byte lanes
// -----------------------------------------------------------------------------
package sad_pkg;

    localparam int NUM_LANES = 4;   // byte lanes compared per word
    localparam int LANE_W    = 8;
    localparam int SAD_W     = 10;  // 4 * 255 = 1020 fits in 10 bits

    localparam logic [1:0] SAD_REG_A = 2'd0;
    localparam logic [1:0] SAD_REG_B = 2'd1;
    localparam logic [1:0] SAD_REG_2 = 2'd2;
    localparam logic [1:0] SAD_REG_3 = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_e;

    function automatic logic [LANE_W-1:0] abs_diff(input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sad_s00_axi_slave_if.sv
// -----------------------------------------------------------------------------
// sad_s00_axi_slave_if
// AXI4-Lite bundle for the S00_AXI port (AW, W, B, AR, R channels).
//   master modport: the PS / VIP side, drives addresses, data and ready for
//                   the response channels.
//   slave modport : the sad_s00_axi_slave side.
// Clock and reset are kept outside the bundle as plain ports.
// -----------------------------------------------------------------------------
interface sad_s00_axi_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

// File: rtl/sad_byte_pipe.sv
// -----------------------------------------------------------------------------
// sad_byte_pipe
// Two-stage byte-lane sum of absolute differences.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   a_i, b_i      : operand words, viewed as NUM_LANES unsigned bytes
//   trig_i        : one-cycle strobe on the edge that updates a_i / b_i
//   sum_o         : registered SAD (SAD_W bits), holds between triggers
//   vld_o         : one-cycle pulse when sum_o has just been updated
// -----------------------------------------------------------------------------
module sad_byte_pipe
    import sad_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_LANES-1:0][LANE_W-1:0] a_i,
    input  logic [NUM_LANES-1:0][LANE_W-1:0] b_i,
    input  logic                             trig_i,
    output logic [SAD_W-1:0]                 sum_o,
    output logic                             vld_o
);

    localparam int STAGES = 2;

    // vld_pipe_q[0] : trigger seen; operands become valid this cycle
    // vld_pipe_q[1] : stage 1 (per-lane abs diff) loaded
    // vld_pipe_q[2] : stage 2 (sum) loaded
    // The operands come straight from the register file, which updates on
    // the trigger edge itself, so stage 1 samples one edge later.
    logic [STAGES:0]                  vld_pipe_q;
    logic [NUM_LANES-1:0][LANE_W-1:0] diff_d, diff_q;
    logic [SAD_W-1:0]                 sum_d, sum_q;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign diff_d[k] = abs_diff(a_i[k], b_i[k]);
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            sum_d = sum_d + SAD_W'(diff_q[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe_q <= '0;
            diff_q     <= '0;
            sum_q      <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], trig_i};
            if (vld_pipe_q[0]) diff_q <= diff_d;
            if (vld_pipe_q[1]) sum_q  <= sum_d;
        end
    end

    assign sum_o = sum_q;
    assign vld_o = vld_pipe_q[STAGES];

endmodule

// File: rtl/sad_s00_axi_slave.sv
// -----------------------------------------------------------------------------
// sad_s00_axi_slave
// AXI4-Lite slave with four 32-bit R/W registers (word index = ADDR[3:2])
// and a SAD of the byte lanes of registers 0 and 1 exported to the datapath.
//   S_AXI_ACLK    : clock
//   S_AXI_ARESETN : asynchronous active-low reset
//   s_axi         : AXI4-Lite slave bundle (AW, W, B, AR, R)
//   sad_result    : zero-extended 10-bit SAD of reg0 / reg1 byte lanes
//   sad_valid     : one-cycle pulse when sad_result updates
// Write: AW and W must be valid together; both READYs pulse in the accepting
// cycle, the register is written on that edge and BVALID follows. Read: AR is
// accepted whenever no read response is pending; RDATA is captured on the
// accepting edge, so a same-cycle write to the same register is not visible.
// -----------------------------------------------------------------------------
module sad_s00_axi_slave
    import sad_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    sad_s00_axi_slave_if.slave            s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] sad_result,
    output logic                          sad_valid
);

    localparam int NB       = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NUM_REGS = 1 << IDX_W;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]               rdata_q, rdata_d;

    logic             wr_go, rd_go, sad_trig;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [SAD_W-1:0] sad_sum;
    logic             unused_bits;

    assign wr_idx = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    // Sub-word address bits and protection are don't-care for this slave.
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // ---------------------------------------------------------------- write
    // READY is combinational on the valids; it is qualified with reset so
    // the handshake outputs read low for as long as reset is held.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_go      = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (S_AXI_ARESETN && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
                    wr_go      = 1'b1;
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi.S_AXI_BREADY) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (s_axi.S_AXI_WSTRB[i]) begin
                    regs_d[wr_idx][8*i +: 8] = s_axi.S_AXI_WDATA[8*i +: 8];
                end
            end
        end
    end

    // Any committed write to A or B restarts the SAD, even with WSTRB = 0.
    assign sad_trig = wr_go && (wr_idx == IDX_W'(SAD_REG_A) ||
                                wr_idx == IDX_W'(SAD_REG_B));

    // ----------------------------------------------------------------- read
    always_comb begin
        rd_state_d = rd_state_q;
        rd_go      = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (S_AXI_ARESETN && s_axi.S_AXI_ARVALID) begin
                    rd_go      = 1'b1;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_axi.S_AXI_RREADY) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // regs_q (not regs_d): a read racing a write returns the old value.
    assign rdata_d = rd_go ? regs_q[rd_idx] : rdata_q;

    // ------------------------------------------------------------ registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            regs_q     <= '0;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            regs_q     <= regs_d;
            rdata_q    <= rdata_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign s_axi.S_AXI_AWREADY = wr_go;
    assign s_axi.S_AXI_WREADY  = wr_go;
    assign s_axi.S_AXI_BVALID  = (wr_state_q == WR_RESP);
    assign s_axi.S_AXI_BRESP   = AXI_RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = rd_go;
    assign s_axi.S_AXI_RVALID  = (rd_state_q == RD_DATA);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = AXI_RESP_OKAY;

    // ------------------------------------------------------------------ SAD
    sad_byte_pipe u_sad_pipe (
        .clk_i  (S_AXI_ACLK),
        .rst_ni (S_AXI_ARESETN),
        .a_i    (regs_q[SAD_REG_A]),
        .b_i    (regs_q[SAD_REG_B]),
        .trig_i (sad_trig),
        .sum_o  (sad_sum),
        .vld_o  (sad_valid)
    );

    assign sad_result = {{(C_S_AXI_DATA_WIDTH-SAD_W){1'b0}}, sad_sum};

endmodule
